// File: rtl/note_grid_pkg.sv
// Note grid geometry shared by the note decoder, this serializer and the VGA draw FSM.
// Note index i lives at column X = i / ROWS, row Y = i % ROWS.
package note_grid_pkg;

  localparam int COLS = 5;
  localparam int ROWS = 6;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int XYW  = XW + YW;

  // Repeated-subtraction mapping; unrolls to comparators, no divider.
  function automatic logic [XYW-1:0] idx_to_xy(input int unsigned idx,
                                               input int unsigned rows = ROWS);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = '0;
    y = YW'(idx);
    for (int c = 1; c < 32; c++) begin
      if (idx >= c * rows) begin
        x = XW'(c);
        y = YW'(idx - c * rows);
      end
    end
    return {x, y};
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot isolation and any-set flag for a mask.
module lsb_prio_enc #(
  parameter int N  = 30,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          any_set
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign onehot  = mask & (~mask + N'(1));
  assign any_set = |mask;

endmodule

// File: rtl/note_coord_serializer.sv
// Collects multi-hot note strikes into a pending mask and emits them LSB-first as
// (X, Y) grid coordinates over valid/ready, one per cycle when the consumer is ready.
module note_coord_serializer #(
  parameter int COLS = note_grid_pkg::COLS,
  parameter int ROWS = note_grid_pkg::ROWS,
  parameter int N    = COLS * ROWS,
  parameter int XW   = note_grid_pkg::XW,
  parameter int YW   = note_grid_pkg::YW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  note_in,
  input  logic          note_load,
  input  logic          clear,
  output logic          coord_valid,
  input  logic          coord_ready,
  output logic [XW-1:0] coord_x,
  output logic [YW-1:0] coord_y,
  output logic [5:0]    pend_cnt,
  output logic          busy,
  output logic          frame_done
);
  import note_grid_pkg::*;

  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int PXW = note_grid_pkg::XW;
  localparam int PYW = note_grid_pkg::YW;

  logic [N-1:0]       pend_p0, pend_nxt, sel_onehot;
  logic [IW-1:0]      sel_idx;
  logic               any_set, take, vld_p1, vld_nxt, busy_nxt;
  logic [XW-1:0]      x_p1;
  logic [YW-1:0]      y_p1;
  logic               frame_done_p1;
  logic [PXW+PYW-1:0] sel_xy;

  // Stage p0: pending mask and lowest-index selection
  lsb_prio_enc #(.N(N), .IW(IW)) u_enc (
    .mask    (pend_p0),
    .idx     (sel_idx),
    .onehot  (sel_onehot),
    .any_set (any_set)
  );

  assign sel_xy = idx_to_xy(32'(sel_idx), unsigned'(ROWS));
  assign take   = (!vld_p1 || coord_ready) && any_set;

  // A reload of the bit being taken survives because the OR follows the clear.
  always_comb begin
    pend_nxt = pend_p0 & ~(take ? sel_onehot : '0);
    if (note_load) pend_nxt = pend_nxt | note_in;
    vld_nxt = vld_p1;
    if (take) vld_nxt = 1'b1;
    else if (vld_p1 && coord_ready) vld_nxt = 1'b0;
    if (clear) begin
      pend_nxt = '0;
      vld_nxt  = 1'b0;
    end
    busy_nxt = (|pend_nxt) || vld_nxt;
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N; i++) pend_cnt = pend_cnt + 6'(pend_p0[i]);
  end

  // Stage p1: output coordinate register and end-of-frame pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_p0       <= '0;
      vld_p1        <= 1'b0;
      x_p1          <= '0;
      y_p1          <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      pend_p0       <= pend_nxt;
      vld_p1        <= vld_nxt;
      frame_done_p1 <= busy && !busy_nxt && !clear;
      if (take && !clear) begin
        x_p1 <= XW'(sel_xy[PXW+PYW-1 -: PXW]);
        y_p1 <= YW'(sel_xy[PYW-1:0]);
      end
    end
  end

  assign busy        = (|pend_p0) || vld_p1;
  assign coord_valid = vld_p1;
  assign coord_x     = x_p1;
  assign coord_y     = y_p1;
  assign frame_done  = frame_done_p1;

endmodule

// File: tb/tb_note_coord_serializer.sv
// Randomized and directed bench for note_coord_serializer against a cycle-level
// behavioural model of the pending set and the output handshake.
module tb_note_coord_serializer;
  localparam int COLS = 5;
  localparam int ROWS = 6;
  localparam int N    = COLS * ROWS;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] note_in = '0;
  logic         note_load = 1'b0;
  logic         clear = 1'b0;
  logic         coord_ready = 1'b0;
  logic         coord_valid, busy, frame_done;
  logic [2:0]   coord_x, coord_y;
  logic [5:0]   pend_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] m_pend = '0;
  logic         m_vld = 1'b0;
  int           m_x = 0, m_y = 0;
  logic         m_fd = 1'b0;

  logic [14:0] dut_vec;

  always #5 clock = ~clock;

  note_coord_serializer #(.COLS(COLS), .ROWS(ROWS), .N(N), .XW(3), .YW(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .note_in     (note_in),
    .note_load   (note_load),
    .clear       (clear),
    .coord_valid (coord_valid),
    .coord_ready (coord_ready),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .pend_cnt    (pend_cnt),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  assign dut_vec = {coord_valid, coord_x, coord_y, pend_cnt, busy, frame_done};

  function automatic logic [14:0] model_vec();
    logic b;
    b = (m_pend != '0) || m_vld;
    return {m_vld, 3'(m_x), 3'(m_y), 6'($countones(m_pend)), b, m_fd};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_vld = 1'b0; m_x = 0; m_y = 0; m_fd = 1'b0;
  endtask

  // One clock of the pending-set model, from the inputs applied this cycle.
  task automatic model_update();
    logic [N-1:0] np;
    logic nv, was_busy;
    int low;
    was_busy = (m_pend != '0) || m_vld;
    np = m_pend;
    nv = m_vld;
    if (clear) begin
      np = '0;
      nv = 1'b0;
    end else begin
      if ((!m_vld || coord_ready) && m_pend != '0) begin
        low = 0;
        while (!m_pend[low]) low++;
        m_x = low / ROWS;
        m_y = low % ROWS;
        nv = 1'b1;
        np[low] = 1'b0;
      end else if (m_vld && coord_ready) begin
        nv = 1'b0;
      end
      if (note_load) np = np | note_in;
    end
    m_fd = was_busy && !clear && !((np != '0) || nv);
    m_pend = np;
    m_vld = nv;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #3;
    n_vec++;
    if (dut_vec !== 15'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_empty_load();
    note_in = '0; note_load = 1'b1; coord_ready = 1'b1;
    tick();
    note_load = 1'b0;
    tick();
    n_vec++;
    if (dut_vec !== 15'd0) begin
      n_err++;
      $display("FAIL empty_load: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_single();
    coord_ready = 1'b1;
    note_in = 30'd1 << 13; note_load = 1'b1;
    tick();
    note_load = 1'b0; note_in = '0;
    n_vec++;
    if (coord_valid !== 1'b0 || pend_cnt !== 6'd1) begin
      n_err++;
      $display("FAIL single_load: got valid=%b cnt=%0d want 0/1", coord_valid, pend_cnt);
    end
    tick();
    n_vec++;
    if (coord_valid !== 1'b1 || coord_x !== 3'd2 || coord_y !== 3'd1) begin
      n_err++;
      $display("FAIL single_xy: got v=%b (%0d,%0d) want 1 (2,1)", coord_valid, coord_x, coord_y);
    end
    tick();
    n_vec++;
    if (coord_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got v=%b fd=%b busy=%b want 0/1/0", coord_valid, frame_done, busy);
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b0 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL single_fd_once: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_chord();
    int ex[3] = '{0, 1, 4};
    int ey[3] = '{0, 1, 5};
    int ec[3] = '{2, 1, 0};
    coord_ready = 1'b1;
    note_in = (30'd1 << 29) | (30'd1 << 7) | 30'd1; note_load = 1'b1;
    tick();
    note_load = 1'b0; note_in = '0;
    n_vec++;
    if (pend_cnt !== 6'd3) begin
      n_err++;
      $display("FAIL chord_cnt0: got %0d want 3", pend_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (coord_valid !== 1'b1 || int'(coord_x) != ex[k] || int'(coord_y) != ey[k] || int'(pend_cnt) != ec[k]) begin
        n_err++;
        $display("FAIL chord_%0d: got v=%b (%0d,%0d) cnt=%0d want 1 (%0d,%0d) cnt=%0d",
                 k, coord_valid, coord_x, coord_y, pend_cnt, ex[k], ey[k], ec[k]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    coord_ready = 1'b0;
    note_in = (30'd1 << 2) | (30'd1 << 6); note_load = 1'b1;
    tick();
    note_load = 1'b0; note_in = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (coord_valid !== 1'b1 || coord_x !== 3'd0 || coord_y !== 3'd2 || pend_cnt !== 6'd1) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b (%0d,%0d) cnt=%0d want 1 (0,2) cnt=1",
                 k, coord_valid, coord_x, coord_y, pend_cnt);
      end
      if (k < 3) tick();
    end
    coord_ready = 1'b1;
    tick();
    n_vec++;
    if (coord_valid !== 1'b1 || coord_x !== 3'd1 || coord_y !== 3'd0 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL bp_release: got %h want %h", dut_vec, model_vec());
    end
    tick(); tick();
  endtask

  task automatic test_reload();
    coord_ready = 1'b1;
    note_in = 30'd1 << 5; note_load = 1'b1;
    tick();
    tick();
    note_load = 1'b0; note_in = '0;
    n_vec++;
    if (coord_valid !== 1'b1 || coord_x !== 3'd0 || coord_y !== 3'd5 || pend_cnt !== 6'd1) begin
      n_err++;
      $display("FAIL reload_first: got v=%b (%0d,%0d) cnt=%0d want 1 (0,5) cnt=1",
               coord_valid, coord_x, coord_y, pend_cnt);
    end
    tick();
    n_vec++;
    if (coord_valid !== 1'b1 || coord_x !== 3'd0 || coord_y !== 3'd5 || pend_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL reload_second: got v=%b (%0d,%0d) cnt=%0d want 1 (0,5) cnt=0",
               coord_valid, coord_x, coord_y, pend_cnt);
    end
    tick();
    n_vec++;
    if (coord_valid !== 1'b0 || frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL reload_end: got v=%b fd=%b want 0/1", coord_valid, frame_done);
    end
    tick();
  endtask

  task automatic test_clear();
    coord_ready = 1'b1;
    note_in = 30'h3FFF_FFFF; note_load = 1'b1;
    tick();
    note_load = 1'b0; note_in = '0;
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if (pend_cnt !== 6'd26 || dut_vec !== model_vec()) begin
      n_err++;
      $display("FAIL clear_pre: got %h want %h", dut_vec, model_vec());
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if (coord_valid !== 1'b0 || pend_cnt !== 6'd0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_flush: got v=%b cnt=%0d fd=%b busy=%b want 0/0/0/0",
               coord_valid, pend_cnt, frame_done, busy);
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_nofd: got fd=%b want 0", frame_done);
    end
  endtask

  task automatic test_reset_mid();
    coord_ready = 1'b1;
    note_in = 30'h3FFF_FFFF; note_load = 1'b1;
    tick();
    note_load = 1'b0; note_in = '0;
    tick(); tick(); tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (dut_vec !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h want 0", dut_vec);
    end
    tick();
    n_vec++;
    if (dut_vec !== 15'd0) begin
      n_err++;
      $display("FAIL reset_held: got %h want 0", dut_vec);
    end
    reset = 1'b0;
    tick(); tick();
    n_vec++;
    if (dut_vec !== 15'd0) begin
      n_err++;
      $display("FAIL reset_noreplay: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      note_in     = N'($urandom & $urandom);
      note_load   = ($urandom_range(3) == 0);
      coord_ready = ($urandom_range(3) != 0);
      clear       = ($urandom_range(59) == 0);
      tick();
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        $display("FAIL random_%0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
    note_load = 1'b0; clear = 1'b0; coord_ready = 1'b1; note_in = '0;
    for (int k = 0; k < 40; k++) tick();
    n_vec++;
    if (dut_vec !== model_vec() || busy !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: got %h want %h", dut_vec, model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_empty_load();
    test_single();
    test_chord();
    test_backpressure();
    test_reload();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_coord_serializer.md
# note_coord_serializer

Parametrised successor to the single-note decoder. Accepts a multi-hot note vector, where several bars and notes can strike in the same beat, and holds the struck notes in a pending mask. It then emits them one at a time as (X, Y) grid coordinates over a valid/ready handshake. It sits between the song datapath's note output and the VGA drawing FSM, which consumes one coordinate per draw operation.

## Interface
Parameters:
- COLS, 5, number of metal bars (X range 0..COLS-1)
- ROWS, 6, notes per bar (Y range 0..ROWS-1)
- N, COLS*ROWS, note vector width (derived; must be ≤ 32)
- XW, 3, X coordinate width
- YW, 3, Y coordinate width

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- note_in  in  N  multi-hot note vector; bit i maps to X = i / ROWS, Y = i % ROWS
- note_load  in  1  when high, OR note_in into the pending mask this cycle
- clear  in  1  synchronous flush of the pending mask and the output register
- coord_valid  out  1  coord_x/coord_y hold a valid coordinate
- coord_ready  in  1  consumer accepts the coordinate when high with coord_valid
- coord_x  out  XW  bar index
- coord_y  out  YW  note index within the bar
- pend_cnt  out  6  popcount of the pending mask (combinational from the register)
- busy  out  1  pending mask non-zero or coord_valid high
- frame_done  out  1  one-cycle pulse when busy falls

## Operation
- Pending mask `pend[N-1:0]`. Next-state value: `(pend & ~sel_onehot) | (note_load ? note_in : 0)`.
- Selection: the lowest set bit of the registered `pend` (LSB-first, column-major order).
- Output register load condition is `(!coord_valid || coord_ready) && pend != 0`. On load:
  - coord_x and coord_y take the selected index mapping;
  - the selected bit is cleared;
  - coord_valid is set.
- If the load condition is false and `coord_valid && coord_ready`, coord_valid clears.
- If note_load re-asserts a bit in the same cycle that bit is selected, the load wins: the bit stays pending and is emitted again later.
- Bits already pending are merged on note_load; no overflow or error condition exists.
- clear has priority over note_load and selection. It zeroes pend and coord_valid, and frame_done does not pulse.
- Handshake rule: while `coord_valid && !coord_ready`, coord_x and coord_y are held stable.
- The index-to-XY mapping is computed by a constant loop or lookup, not by a runtime divider.

## Timing
- Reset values: pend = 0, coord_valid = 0, coord_x = 0, coord_y = 0, busy = 0, frame_done = 0, pend_cnt = 0.
- Latency: note_load sampled at edge t gives coord_valid = 1 after edge t+1 (when the output register is free).
- Throughput: one coordinate per cycle while coord_ready is held high.
- frame_done: registered. It is high for exactly the one cycle following the edge at which busy goes 1→0.
- A note_in pattern with no bits set and note_load high causes no state change.
- Reset mid-emission: all outputs return to their reset values immediately (asynchronously). A coordinate presented before reset is never replayed.

## Structure
- Shared package `note_grid_pkg` holds:
  - COLS and ROWS defaults;
  - XW and YW;
  - the function `idx_to_xy(idx)` returning the packed {x, y};
  - this function is also used by the existing decoder and the draw FSM.
- Sub-module `lsb_prio_enc #(N)`: inputs the mask; outputs the index, the one-hot selection and any_set.
- Top level holds the pending register, the output register, busy/frame_done logic and the popcount.

## Test plan
- Single note: note_in = 1<<13 with load → next cycle valid, x = 2, y = 1; with ready high, valid drops after one cycle and frame_done pulses once.
- Chord: bits {29, 7, 0} loaded together with ready high → coordinates (0,0), (1,1), (4,5) on consecutive cycles; pend_cnt sequence 3, 2, 1, 0.
- Backpressure: load bits {2, 6}, ready low for 4 cycles → (0,2) held stable the whole time, pend_cnt = 1; after ready rises, (1,0) follows the next cycle.
- Reload race: bit 5 pending and being selected while note_load with note_in = 1<<5 → (0,5) is emitted twice.
- Clear and reset: load 0x3FFFFFFF, accept 3 coordinates, assert clear → valid = 0, pend_cnt = 0, no frame_done; repeat with reset asserted mid-stream → all outputs are zero while reset is high.
